// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: decodes one instruction at a time and steps it through EXEC/MEM/WB.
// Latency: ready again 2 (STORE), 3 (ALU/ALUI) or 4 (LOAD) cycles from the transfer edge.
// Backpressure: instr_ready only in IDLE; a held instr_valid is taken at the next IDLE edge. Option: R0_ZERO_EN.
module instr_sequencer #(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       status,
    output logic             write,
    output logic [4:0]       writeReg,
    output logic [4:0]       readA,
    output logic [4:0]       readB,
    output logic [4:0]       sel,
    output logic             muxSel,
    output logic             cin,
    output logic             writeRam,
    output logic             wb_sel,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             err_illegal
);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_HALTED} state_t;

    localparam logic [2:0] C_NOP   = 3'b000;
    localparam logic [2:0] C_ALU   = 3'b001;
    localparam logic [2:0] C_ALUI  = 3'b010;
    localparam logic [2:0] C_LOAD  = 3'b011;
    localparam logic [2:0] C_STORE = 3'b100;
    localparam logic [2:0] C_HALT  = 3'b101;

    state_t           state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic [4:0]       sel_q, sel_d, rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic             cin_q, cin_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             err_q, err_d;
    logic             xfer;
    logic             unused_bits;

    assign unused_bits = ^instr[7:0];

    // Gated by reset so the upstream never sees ready while the sequencer is held.
    assign instr_ready = (state_q == S_IDLE) && reset;
    assign xfer        = instr_valid && instr_ready;
    assign flags       = flags_q;
    assign retired     = retired_q;
    assign halted      = (state_q == S_HALTED);
    assign err_illegal = err_q;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        cin_d     = cin_q;
        flags_d   = flags_q;
        retired_d = retired_q;
        err_d     = err_q;
        write     = 1'b0;
        writeReg  = '0;
        readA     = '0;
        readB     = '0;
        sel       = '0;
        muxSel    = 1'b0;
        cin       = 1'b0;
        writeRam  = 1'b0;
        wb_sel    = 1'b0;

        // Control pins come straight from the latched fields and hold from EXEC through WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            writeReg = rd_q;
            readA    = ra_q;
            readB    = rb_q;
            sel      = sel_q;
            muxSel   = (cls_q == C_ALUI);
            cin      = cin_q;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    cls_d = instr[31:29];
                    sel_d = instr[28:24];
                    rd_d  = instr[23:19];
                    ra_d  = instr[18:14];
                    rb_d  = instr[13:9];
                    cin_d = instr[8];
                    case (instr[31:29])
                        C_NOP: retired_d = retired_q + CNT_W'(1);
                        C_HALT: begin
                            retired_d = retired_q + CNT_W'(1);
                            state_d   = S_HALTED;
                        end
                        C_ALU, C_ALUI, C_LOAD, C_STORE: state_d = S_EXEC;
                        default: begin
                            err_d   = 1'b1;
                            state_d = HALT_ON_ILLEGAL ? S_HALTED : S_IDLE;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if (cls_q == C_STORE) begin
                    writeRam  = 1'b1;
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_IDLE;
                end else if (cls_q == C_LOAD) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                wb_sel  = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
`ifdef R0_ZERO_EN
                write = (rd_q != 5'd0);
`else
                write = 1'b1;
`endif
                wb_sel = (cls_q == C_LOAD);
                if (cls_q == C_ALU || cls_q == C_ALUI) begin
                    flags_d = status;
                end
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cls_q     <= '0;
            sel_q     <= '0;
            rd_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            cin_q     <= 1'b0;
            flags_q   <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            sel_q     <= sel_d;
            rd_q      <= rd_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            cin_q     <= cin_d;
            flags_q   <= flags_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table of single instructions plus hand-written multi-cycle sequences.
module tb_instr_sequencer;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    status;
    logic          write;
    logic [4:0]    writeReg, readA, readB, sel;
    logic          muxSel, cin, writeRam, wb_sel;
    logic [3:0]    flags;
    logic [CW-1:0] retired;
    logic          halted, err_illegal;

    instr_sequencer #(.CNT_W(CW), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .status(status), .write(write), .writeReg(writeReg),
        .readA(readA), .readB(readB), .sel(sel), .muxSel(muxSel), .cin(cin),
        .writeRam(writeRam), .wb_sel(wb_sel), .flags(flags), .retired(retired),
        .halted(halted), .err_illegal(err_illegal)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       wr;
        logic       wram;
        logic [4:0] wreg, ra, rb, sel;
        logic       mux, cin, wbs;
    } ev_t;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  st;
        int          lat;
        logic        ev;
        ev_t         e;
        logic        cnt;
        logic        flg;
        logic        ill;
    } vec_t;

    ev_t           evq[$];
    logic [CW-1:0] exp_ret = '0;
    logic [3:0]    exp_flags = '0;
    logic          exp_err = 1'b0;

    function automatic vec_t mkv(input logic [2:0] c, input logic [4:0] s, input logic [4:0] rd,
                                 input logic [4:0] ra, input logic [4:0] rb, input logic ci,
                                 input logic [3:0] st);
        vec_t v;
        ev_t  e;
        v.w   = {c, s, rd, ra, rb, ci, 8'hA5};
        v.st  = st;
        v.lat = (c == 3'd1 || c == 3'd2) ? 3 : (c == 3'd3) ? 4 : (c == 3'd4) ? 2 : 1;
        v.ill = c[2] & c[1];
        v.cnt = !v.ill;
        v.flg = (c == 3'd1 || c == 3'd2);
        e.wr  = (c == 3'd1 || c == 3'd2 || c == 3'd3);
`ifdef R0_ZERO_EN
        if (rd == 5'd0) e.wr = 1'b0;
`endif
        e.wram = (c == 3'd4);
        e.wreg = rd;
        e.ra   = ra;
        e.rb   = rb;
        e.sel  = s;
        e.mux  = (c == 3'd2);
        e.cin  = ci;
        e.wbs  = (c == 3'd3);
        v.ev   = e.wr || e.wram;
        v.e    = e;
        return v;
    endfunction

    // Scoreboard: every write/writeRam pulse consumes one expected datapath event.
    always @(negedge clock) begin : monitor
        ev_t e;
        if (reset && (write || writeRam)) begin
            chk("write_and_writeRam_exclusive", {31'b0, write & writeRam}, 32'd0);
            if (evq.size() == 0) begin
                chk("unexpected_datapath_event", 32'd1, 32'd0);
            end else begin
                e = evq.pop_front();
                chk("ev_write", {31'b0, write}, {31'b0, e.wr});
                chk("ev_writeRam", {31'b0, writeRam}, {31'b0, e.wram});
                chk("ev_writeReg", {27'b0, writeReg}, {27'b0, e.wreg});
                chk("ev_readA", {27'b0, readA}, {27'b0, e.ra});
                chk("ev_readB", {27'b0, readB}, {27'b0, e.rb});
                chk("ev_sel", {27'b0, sel}, {27'b0, e.sel});
                chk("ev_muxSel", {31'b0, muxSel}, {31'b0, e.mux});
                chk("ev_cin", {31'b0, cin}, {31'b0, e.cin});
                chk("ev_wb_sel", {31'b0, wb_sel}, {31'b0, e.wbs});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int lat;
        int n;
        @(negedge clock);
        instr = v.w;
        status = v.st;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        if (v.ev) evq.push_back(v.e);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!instr_ready && lat < 20);
        chk("latency", lat, v.lat);
        if (v.cnt) exp_ret = exp_ret + 1'b1;
        if (v.flg) exp_flags = v.st;
        if (v.ill) exp_err = 1'b1;
        chk("retired", {28'b0, retired}, {28'b0, exp_ret});
        chk("flags", {28'b0, flags}, {28'b0, exp_flags});
        chk("err_illegal", {31'b0, err_illegal}, {31'b0, exp_err});
        chk("halted_clear", {31'b0, halted}, 32'd0);
        chk("events_drained", evq.size(), 32'd0);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   n;
        reset = 1'b0;
        instr = 32'h0;
        instr_valid = 1'b0;
        status = 4'h0;

        tbl[0] = mkv(3'd1, 5'd2, 5'd3, 5'd1, 5'd2, 1'b0, 4'b1010);
        tbl[0].w = 32'h22184400;
        tbl[1] = mkv(3'd3, 5'd0, 5'd7, 5'd4, 5'd5, 1'b0, 4'b0011);
        tbl[2] = mkv(3'd4, 5'd1, 5'd2, 5'd6, 5'd9, 1'b0, 4'b1111);
        tbl[3] = mkv(3'd2, 5'd7, 5'd5, 5'd8, 5'd3, 1'b1, 4'b0101);
        tbl[4] = mkv(3'd0, 5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 4'b0000);
        tbl[5] = mkv(3'd7, 5'd4, 5'd4, 5'd4, 5'd4, 1'b0, 4'b1100);
        tbl[6] = mkv(3'd1, 5'd3, 5'd0, 5'd2, 5'd1, 1'b0, 4'b1111);
        tbl[7] = mkv(3'd6, 5'd1, 5'd1, 5'd1, 5'd1, 1'b1, 4'b0001);
        tbl[8] = mkv(3'd1, 5'd31, 5'd31, 5'd31, 5'd31, 1'b1, 4'b1001);
        tbl[9] = mkv(3'd3, 5'd5, 5'd0, 5'd31, 5'd0, 1'b1, 4'b0110);

        #3;
        chk("reset_instr_ready", {31'b0, instr_ready}, 32'd0);
        chk("reset_flags_outputs", {20'b0, write, writeRam, wb_sel, muxSel, cin, halted, err_illegal,
                                    flags, retired}, 32'd0);
        chk("reset_addr_outputs", {12'b0, writeReg, readA, readB, sel}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready_after_release", {31'b0, instr_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Enough NOPs to wrap the narrow counter.
        for (int i = 0; i < 18; i++) run_vec(mkv(3'd0, 5'(i), 5'(i), 5'd0, 5'd0, 1'b0, 4'h0));

        // Reset asserted during the WB cycle of a LOAD.
        v = mkv(3'd3, 5'd0, 5'd7, 5'd4, 5'd5, 1'b0, 4'h0);
        @(negedge clock);
        instr = v.w;
        instr_valid = 1'b1;
        evq.push_back(v.e);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(negedge clock);
        chk("load_exec_write", {31'b0, write}, 32'd0);
        @(negedge clock);
        chk("load_mem_write", {31'b0, write}, 32'd0);
        chk("load_mem_wb_sel", {31'b0, wb_sel}, 32'd1);
        @(negedge clock);
        chk("load_wb_write", {31'b0, write}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_write", {31'b0, write}, 32'd0);
        chk("midreset_writeRam", {31'b0, writeRam}, 32'd0);
        chk("midreset_retired", {28'b0, retired}, 32'd0);
        chk("midreset_ready", {31'b0, instr_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        exp_ret = '0;
        exp_flags = '0;
        exp_err = 1'b0;
        @(negedge clock);
        chk("post_reset_idle_ready", {31'b0, instr_ready}, 32'd1);
        chk("post_reset_err", {31'b0, err_illegal}, 32'd0);
        chk("post_reset_events", evq.size(), 32'd0);

        // Back-to-back ALUI then HALT with instr_valid held high.
        v = mkv(3'd2, 5'd7, 5'd5, 5'd1, 5'd2, 1'b0, 4'b0110);
        @(negedge clock);
        instr = v.w;
        status = v.st;
        instr_valid = 1'b1;
        evq.push_back(v.e);
        @(posedge clock);
        #1;
        instr = mkv(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 4'h0).w;
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clock);
            n++;
        end
        exp_ret = exp_ret + 2'd2;
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_ready", {31'b0, instr_ready}, 32'd0);
        chk("halt_retired", {28'b0, retired}, {28'b0, exp_ret});
        chk("halt_flags", {28'b0, flags}, 32'b0110);
        chk("halt_events", evq.size(), 32'd0);
        instr = mkv(3'd1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 4'h0).w;
        repeat (8) @(negedge clock);
        instr_valid = 1'b0;
        chk("halted_ignores_retired", {28'b0, retired}, {28'b0, exp_ret});
        chk("halted_stays", {31'b0, halted}, 32'd1);
        chk("halted_ready", {31'b0, instr_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
